// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, parity mode codes and the frame-length helper.
package uart_pkg;

    // One-cold encoding, as used by the other UART blocks.
    typedef enum logic [4:0] {
        ST_IDLE   = 5'b11110,
        ST_START  = 5'b11101,
        ST_DATA   = 5'b11011,
        ST_PARITY = 5'b10111,
        ST_STOP   = 5'b01111
    } uart_state_e;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // Bit periods in one frame: start + data + optional parity + 1 or 2 stops.
    function automatic int unsigned frame_bits(input int unsigned data_bits,
                                               input logic [1:0]  parity_mode,
                                               input logic        stop2);
        int unsigned n;
        n = 1 + data_bits + 1;
        if (parity_mode == PAR_EVEN || parity_mode == PAR_ODD) begin
            n = n + 1;
        end
        if (stop2) begin
            n = n + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Oversample tick counter: flags the tick that closes each bit period.
module uart_bit_timer #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned CNT_W      = $clog2(OVERSAMPLE)
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_tick,
    output logic o_bit_end
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OVERSAMPLE - 1);

    logic [CNT_W-1:0] cnt_q;

    assign o_bit_end = i_tick && !i_clear && (cnt_q == CNT_MAX);

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            cnt_q <= '0;
        end else if (i_tick) begin
            cnt_q <= o_bit_end ? '0 : cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: DATA_BITS payload, run-time parity and stop count,
// ready/start handshake and a one-cycle done pulse.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned CNT_W      = $clog2(OVERSAMPLE)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_tick,
    input  logic                 i_tx_start,
    input  logic [DATA_BITS-1:0] i_data,
    input  logic [1:0]           i_parity_mode,
    input  logic                 i_stop2,
    output logic                 o_tx,
    output logic                 o_tx_ready,
    output logic                 o_flag_tx_done
);

    localparam int unsigned IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [1:0]           par_q, par_d;
    logic                 stop2_q, stop2_d;
    logic                 stop_idx_q, stop_idx_d;
    logic                 tx_q, tx_d;
    logic                 ready_q, ready_d;
    logic                 done_q, done_d;
    logic                 fin_q, fin_d;

    logic accept;
    logic bit_end;
    logic timer_clr;
    logic par_en;
    logic par_bit;

    assign accept    = i_tx_start && ready_q;
    assign timer_clr = accept || (state_q == ST_IDLE);
    assign par_en    = (par_q == PAR_EVEN) || (par_q == PAR_ODD);
    assign par_bit   = (par_q == PAR_ODD) ? ~^data_q : ^data_q;

    uart_bit_timer #(
        .OVERSAMPLE (OVERSAMPLE),
        .CNT_W      (CNT_W)
    ) u_bit_timer (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_clear   (timer_clr),
        .i_tick    (i_tick),
        .o_bit_end (bit_end)
    );

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        shift_d    = shift_q;
        idx_d      = idx_q;
        par_d      = par_q;
        stop2_d    = stop2_q;
        stop_idx_d = stop_idx_q;
        ready_d    = ready_q;
        done_d     = 1'b0;
        fin_d      = 1'b0;
        tx_d       = 1'b1;

        case (state_q)
            ST_IDLE: begin
                // fin_q marks the cycle right after the last stop tick.
                if (fin_q) begin
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                end
                if (accept) begin
                    state_d    = ST_START;
                    data_d     = i_data;
                    shift_d    = i_data;
                    par_d      = i_parity_mode;
                    stop2_d    = i_stop2;
                    idx_d      = '0;
                    stop_idx_d = 1'b0;
                    ready_d    = 1'b0;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    idx_d   = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == IDX_LAST) begin
                        state_d = par_en ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (stop2_q && !stop_idx_q) begin
                        stop_idx_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        fin_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase

        // Line level follows the state being entered, keeping o_tx registered.
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = par_bit;
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            data_q     <= '0;
            shift_q    <= '0;
            idx_q      <= '0;
            par_q      <= PAR_NONE;
            stop2_q    <= 1'b0;
            stop_idx_q <= 1'b0;
            tx_q       <= 1'b1;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            fin_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            shift_q    <= shift_d;
            idx_q      <= idx_d;
            par_q      <= par_d;
            stop2_q    <= stop2_d;
            stop_idx_q <= stop_idx_d;
            tx_q       <= tx_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            fin_q      <= fin_d;
        end
    end

    assign o_tx           = tx_q;
    assign o_tx_ready     = ready_q;
    assign o_flag_tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg against a tick-counting frame model.
module tb_uart_tx_cfg;
    import uart_pkg::*;

    localparam int OS = 16;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_tick = 1'b0;
    logic       i_tx_start = 1'b0;
    logic [7:0] i_data = 8'h00;
    logic [1:0] i_parity_mode = 2'b00;
    logic       i_stop2 = 1'b0;
    logic       o_tx;
    logic       o_tx_ready;
    logic       o_flag_tx_done;

    int tests_run = 0;
    int tests_failed = 0;
    int tick_mode = 0;  // 0: every cycle, 255: random, else period
    int phase = 0;
    logic last_tick = 1'b0;

    uart_tx_cfg #(
        .DATA_BITS  (8),
        .OVERSAMPLE (OS)
    ) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_tick         (i_tick),
        .i_tx_start     (i_tx_start),
        .i_data         (i_data),
        .i_parity_mode  (i_parity_mode),
        .i_stop2        (i_stop2),
        .o_tx           (o_tx),
        .o_tx_ready     (o_tx_ready),
        .o_flag_tx_done (o_flag_tx_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic step();
        if (tick_mode == 0) begin
            i_tick = 1'b1;
        end else if (tick_mode == 255) begin
            i_tick = 1'($urandom_range(0, 1));
        end else begin
            i_tick = (phase == 0);
            phase = (phase + 1) % tick_mode;
        end
        @(posedge i_clk);
        #1;
        last_tick = i_tick;
    endtask

    task automatic set_ticks(input int mode);
        tick_mode = mode;
        phase = 0;
    endtask

    // Sends one frame and reports what was observed plus the model's expectations.
    task automatic run_frame(input logic [7:0] d, input logic [1:0] m, input logic s2,
                             input bit noise, input bit keep_start,
                             output int wait_cyc, output logic acc_tx, output logic acc_rdy,
                             output int lat, output int exp_lat, output int tx_err,
                             output int done_cnt, output logic done_rdy);
        logic seq[$];
        int total;
        int ticks;
        logic exp_tx;
        bit fin;
        seq.push_back(1'b0);
        for (int i = 0; i < 8; i++) seq.push_back(d[i]);
        if (m == PAR_EVEN) seq.push_back(^d);
        if (m == PAR_ODD) seq.push_back(~^d);
        seq.push_back(1'b1);
        if (s2) seq.push_back(1'b1);
        total = int'(frame_bits(8, m, s2)) * OS;

        wait_cyc = 0;
        while (o_tx_ready !== 1'b1 && wait_cyc < 1000) begin
            i_tx_start = 1'b0;
            step();
            wait_cyc++;
        end
        i_data = d;
        i_parity_mode = m;
        i_stop2 = s2;
        i_tx_start = 1'b1;
        step();
        acc_tx = o_tx;
        acc_rdy = o_tx_ready;
        done_cnt = o_flag_tx_done ? 1 : 0;
        tx_err = (o_tx !== seq[0]) ? 1 : 0;
        done_rdy = 1'b0;
        ticks = 0;
        lat = -1;
        exp_lat = -1;
        fin = 0;
        for (int k = 1; k <= 5000 && lat < 0; k++) begin
            if (noise) begin
                i_data = 8'($urandom);
                i_parity_mode = 2'($urandom);
                i_stop2 = 1'($urandom);
            end
            if (ticks >= total) i_tx_start = keep_start;
            else i_tx_start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
            if (o_flag_tx_done === 1'b1) begin
                done_cnt++;
                if (lat < 0) begin
                    lat = k;
                    done_rdy = o_tx_ready;
                end
            end
            if (!fin) begin
                ticks += int'(last_tick);
                if (ticks >= total) begin
                    fin = 1;
                    exp_lat = k + 1;
                end
            end
            exp_tx = (ticks < total) ? seq[ticks / OS] : 1'b1;
            if (o_tx !== exp_tx) tx_err++;
        end
        if (!keep_start) i_tx_start = 1'b0;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        i_tx_start = 1'b1;
        step();
        step();
        tests_run += 3;
        if (o_tx !== 1'b1) begin
            tests_failed++; $display("FAIL reset_tx: got %b want 1", o_tx);
        end
        if (o_tx_ready !== 1'b1) begin
            tests_failed++; $display("FAIL reset_ready: got %b want 1", o_tx_ready);
        end
        if (o_flag_tx_done !== 1'b0) begin
            tests_failed++; $display("FAIL reset_done: got %b want 0", o_flag_tx_done);
        end
        i_tx_start = 1'b0;
        i_reset = 1'b0;
        step();
    endtask

    task automatic test_8n1();
        int w, lat, el, te, dc;
        logic at, ar, dr;
        set_ticks(0);
        run_frame(8'hA5, 2'b00, 1'b0, 0, 0, w, at, ar, lat, el, te, dc, dr);
        tests_run += 5;
        if (at !== 1'b0 || ar !== 1'b0) begin
            tests_failed++; $display("FAIL 8n1_accept: tx=%b ready=%b want 0 0", at, ar);
        end
        if (te != 0) begin
            tests_failed++; $display("FAIL 8n1_line: %0d bad cycles want 0", te);
        end
        if (lat != 161) begin
            tests_failed++; $display("FAIL 8n1_done_latency: got %0d want 161", lat);
        end
        if (dc != 1) begin
            tests_failed++; $display("FAIL 8n1_done_count: got %0d want 1", dc);
        end
        if (dr !== 1'b1) begin
            tests_failed++; $display("FAIL 8n1_done_ready: got %b want 1", dr);
        end
    endtask

    task automatic test_parity();
        int w, lat, el, te, dc;
        logic at, ar, dr;
        logic [1:0] modes[3] = '{2'b01, 2'b10, 2'b11};
        int want_lat[3] = '{177, 177, 161};
        set_ticks(0);
        for (int i = 0; i < 3; i++) begin
            run_frame(8'hA5, modes[i], 1'b0, 0, 0, w, at, ar, lat, el, te, dc, dr);
            tests_run += 2;
            if (te != 0) begin
                tests_failed++; $display("FAIL parity_line mode %0d: %0d bad cycles want 0",
                                         modes[i], te);
            end
            if (lat != want_lat[i]) begin
                tests_failed++; $display("FAIL parity_latency mode %0d: got %0d want %0d",
                                         modes[i], lat, want_lat[i]);
            end
        end
    endtask

    task automatic test_stop2();
        int w, lat, el, te, dc;
        logic at, ar, dr;
        set_ticks(4);
        run_frame(8'h3C, 2'b00, 1'b1, 0, 0, w, at, ar, lat, el, te, dc, dr);
        tests_run += 3;
        if (te != 0) begin
            tests_failed++; $display("FAIL stop2_line: %0d bad cycles want 0", te);
        end
        if (lat != el) begin
            tests_failed++; $display("FAIL stop2_latency: got %0d want %0d", lat, el);
        end
        if (dr !== 1'b1) begin
            tests_failed++; $display("FAIL stop2_ready_with_done: got %b want 1", dr);
        end
    endtask

    task automatic test_ignore_busy_start();
        int w, lat, el, te, dc, extra_done, bad_idle;
        logic at, ar, dr;
        set_ticks(0);
        run_frame(8'h00, 2'b00, 1'b0, 1, 0, w, at, ar, lat, el, te, dc, dr);
        extra_done = 0;
        bad_idle = 0;
        i_tx_start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (o_flag_tx_done !== 1'b0) extra_done++;
            if (o_tx_ready !== 1'b1 || o_tx !== 1'b1) bad_idle++;
        end
        tests_run += 4;
        if (te != 0) begin
            tests_failed++; $display("FAIL ignore_line: %0d bad cycles want 0", te);
        end
        if (dc != 1 || lat != el) begin
            tests_failed++; $display("FAIL ignore_done: count %0d at %0d want 1 at %0d",
                                     dc, lat, el);
        end
        if (extra_done != 0) begin
            tests_failed++; $display("FAIL ignore_extra_done: got %0d want 0", extra_done);
        end
        if (bad_idle != 0) begin
            tests_failed++; $display("FAIL ignore_second_frame: %0d busy cycles want 0", bad_idle);
        end
    endtask

    task automatic test_back_to_back();
        int w, lat, el, te, dc;
        logic at, ar, dr;
        set_ticks(0);
        run_frame(8'h5A, 2'b01, 1'b0, 0, 1, w, at, ar, lat, el, te, dc, dr);
        tests_run += 1;
        if (dr !== 1'b1 || lat != el) begin
            tests_failed++; $display("FAIL b2b_first: ready=%b lat=%0d want 1 %0d", dr, lat, el);
        end
        run_frame(8'hC3, 2'b00, 1'b1, 0, 0, w, at, ar, lat, el, te, dc, dr);
        tests_run += 3;
        if (w != 0) begin
            tests_failed++; $display("FAIL b2b_gap: got %0d want 0", w);
        end
        if (at !== 1'b0 || ar !== 1'b0) begin
            tests_failed++; $display("FAIL b2b_start: tx=%b ready=%b want 0 0", at, ar);
        end
        if (te != 0 || lat != el) begin
            tests_failed++; $display("FAIL b2b_second: %0d bad cycles lat %0d want 0 %0d",
                                     te, lat, el);
        end
    endtask

    task automatic test_reset_mid_frame();
        int w, lat, el, te, dc, spurious;
        logic at, ar, dr, pre_tx;
        set_ticks(0);
        i_data = 8'h00;
        i_parity_mode = 2'b00;
        i_stop2 = 1'b0;
        i_tx_start = 1'b1;
        step();
        i_tx_start = 1'b0;
        for (int k = 0; k < OS + 3 * OS + 5; k++) step();
        pre_tx = o_tx;
        i_reset = 1'b1;
        step();
        tests_run += 4;
        if (pre_tx !== 1'b0) begin
            tests_failed++; $display("FAIL midreset_pre_tx: got %b want 0", pre_tx);
        end
        if (o_tx !== 1'b1 || o_tx_ready !== 1'b1) begin
            tests_failed++; $display("FAIL midreset_state: tx=%b ready=%b want 1 1",
                                     o_tx, o_tx_ready);
        end
        spurious = (o_flag_tx_done !== 1'b0) ? 1 : 0;
        i_reset = 1'b0;
        for (int k = 0; k < 200; k++) begin
            step();
            if (o_flag_tx_done !== 1'b0) spurious++;
        end
        if (spurious != 0) begin
            tests_failed++; $display("FAIL midreset_done: got %0d pulses want 0", spurious);
        end
        run_frame(8'h81, 2'b00, 1'b0, 0, 0, w, at, ar, lat, el, te, dc, dr);
        if (te != 0 || lat != 161) begin
            tests_failed++; $display("FAIL midreset_next_frame: %0d bad cycles lat %0d want 0 161",
                                     te, lat);
        end
    endtask

    task automatic test_random();
        int w, lat, el, te, dc, sel, want;
        logic at, ar, dr;
        logic [7:0] d;
        logic [1:0] m;
        logic s2;
        for (int i = 0; i < 12; i++) begin
            sel = $urandom_range(0, 3);
            set_ticks(sel == 0 ? 0 : sel == 1 ? 2 : sel == 2 ? 3 : 255);
            d = 8'($urandom);
            m = 2'($urandom);
            s2 = 1'($urandom);
            run_frame(d, m, s2, 1'($urandom), 0, w, at, ar, lat, el, te, dc, dr);
            want = (sel == 0) ? int'(frame_bits(8, m, s2)) * OS + 1 : el;
            tests_run += 2;
            if (te != 0) begin
                tests_failed++; $display("FAIL rand_line %0d (d=%h m=%0d s2=%b): %0d bad cycles want 0",
                                         i, d, m, s2, te);
            end
            if (lat != want || dc != 1) begin
                tests_failed++; $display("FAIL rand_done %0d: lat %0d count %0d want %0d 1",
                                         i, lat, dc, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_stop2();
        test_ignore_busy_start();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
